boxcar_decimator: RTL and testbench

Boxcar averaging decimator that consumes the registered output of the 8:1 signal-select mux in the PLL signal path. It averages 2^k consecutive signed samples, with k runtime-selectable, and emits one averaged sample per block with a single-cycle valid strobe. A restart input discards the partial block and blanks the input for a fixed number of cycles, so a mux select change never mixes two sources in one average.

---
 rtl/pll_pkg.sv | 7 +
 rtl/boxcar_decimator.sv | 97 +++++++++
 tb/tb_boxcar_decimator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pll_pkg.sv
// Shared constants and types for the PLL signal-path blocks.
package pll_pkg;
  localparam int LOG2_DECIM_W       = 4;
  localparam int LOG2_MAX_DECIM_DEF = 10;

  typedef enum logic {BLANK, ACCUM} decim_state_t;
endpackage

// File: rtl/boxcar_decimator.sv
// Boxcar averaging decimator: averages 2^k signed samples per block and emits a
// registered average with a one-cycle strobe; restart blanks the mux settling window.
module boxcar_decimator
  import pll_pkg::*;
#(
  parameter int WIDTH          = 14,
  parameter int LOG2_MAX_DECIM = LOG2_MAX_DECIM_DEF,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [WIDTH-1:0]  in_i,
  input  logic [LOG2_DECIM_W-1:0]  log2_decim_i,
  input  logic                     restart_i,
  output logic signed [WIDTH-1:0]  out_o,
  output logic                     valid_o
);

  localparam int ACC_W = WIDTH + LOG2_MAX_DECIM;
  localparam int CW    = LOG2_MAX_DECIM + 1;
  localparam int BW    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  decim_state_t                state, state_nxt;
  logic signed [ACC_W-1:0]     acc, acc_nxt, sum;
  logic [LOG2_MAX_DECIM-1:0]   cnt, cnt_nxt;
  logic [LOG2_DECIM_W-1:0]     k_q, k_nxt, k_clamp;
  logic [BW-1:0]               bcnt, bcnt_nxt;
  logic [CW-1:0]               blk_len;
  logic                        blk_done;
  logic signed [WIDTH-1:0]     out_nxt;
  logic                        valid_nxt;

  assign k_clamp  = (log2_decim_i > LOG2_DECIM_W'(LOG2_MAX_DECIM))
                    ? LOG2_DECIM_W'(LOG2_MAX_DECIM) : log2_decim_i;
  assign blk_len  = CW'(1) << k_q;
  assign blk_done = ({1'b0, cnt} == (blk_len - CW'(1)));
  assign sum      = acc + ACC_W'(in_i);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    k_nxt     = k_q;
    bcnt_nxt  = bcnt;
    out_nxt   = out_o;
    valid_nxt = 1'b0;
    // Restart outranks block completion so a select change never emits a mixed average.
    if (restart_i) begin
      acc_nxt   = '0;
      cnt_nxt   = '0;
      k_nxt     = k_clamp;
      bcnt_nxt  = BW'(BLANK_CYCLES - 1);
      state_nxt = BLANK;
    end else begin
      case (state)
        BLANK: begin
          if (bcnt == '0) state_nxt = ACCUM;
          else            bcnt_nxt  = bcnt - BW'(1);
        end
        ACCUM: begin
          if (blk_done) begin
            out_nxt   = WIDTH'(sum >>> k_q);
            valid_nxt = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            k_nxt     = k_clamp;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + LOG2_MAX_DECIM'(1);
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      k_q     <= '0;
      bcnt    <= '0;
      out_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      k_q     <= k_nxt;
      bcnt    <= bcnt_nxt;
      out_o   <= out_nxt;
      valid_o <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Bench for boxcar_decimator: directed scenarios plus random traffic, checked each
// cycle against a sample-queue reference model.
module tb_boxcar_decimator;
  localparam int WIDTH = 14;
  localparam int LMAX  = 10;
  localparam int BLANK = 2;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic signed [WIDTH-1:0] in_i = '0;
  logic [3:0]              log2_decim_i = '0;
  logic                    restart_i = 1'b0;
  logic signed [WIDTH-1:0] out_o;
  logic                    valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending block samples, block exponent, blank cycles left.
  int q[$];
  int mk;
  int blank_left;
  int m_out;
  int m_vld;

  boxcar_decimator #(.WIDTH(WIDTH), .LOG2_MAX_DECIM(LMAX), .BLANK_CYCLES(BLANK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_i(in_i), .log2_decim_i(log2_decim_i),
    .restart_i(restart_i), .out_o(out_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_k(input int k);
    return (k > LMAX) ? LMAX : k;
  endfunction

  function automatic int floor_div(input longint s, input longint d);
    longint r;
    r = s / d;
    if ((s % d != 0) && (s < 0)) r = r - 1;
    return int'(r);
  endfunction

  function automatic void model_reset();
    q.delete();
    mk = 0; blank_left = 0; m_out = 0; m_vld = 0;
  endfunction

  function automatic void model_edge(input int din, input int k, input bit rs);
    longint s;
    s = 0;
    if (rs) begin
      q.delete(); mk = clamp_k(k); blank_left = BLANK; m_vld = 0;
    end else if (blank_left > 0) begin
      blank_left--; m_vld = 0;
    end else begin
      q.push_back(din);
      if (q.size() == (1 << mk)) begin
        foreach (q[i]) s += q[i];
        m_out = floor_div(s, longint'(1) << mk);
        m_vld = 1;
        mk = clamp_k(k);
        q.delete();
      end else m_vld = 0;
    end
  endfunction

  // Model says the next accumulating edge completes the current block.
  function automatic bit model_at_done();
    return (blank_left == 0) && (q.size() == (1 << mk) - 1);
  endfunction

  task automatic step(input int din, input int k, input bit rs);
    in_i = WIDTH'(din); log2_decim_i = 4'(k); restart_i = rs;
    @(posedge clk_i);
    model_edge(din, k, rs);
    #1;
    chk("valid", int'(valid_o), m_vld);
    chk("out", int'(out_o), m_out);
  endtask

  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_out", int'(out_o), 0);
    model_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  // Full-scale constant at clamped k: second strobe (first k=10 block) lands 1025 cycles in.
  task automatic full_scale(input int v);
    int nstb, at;
    nstb = 0; at = -1;
    do_reset();
    for (int j = 1; j <= 1030; j++) begin
      step(v, 15, 1'b0);
      if (valid_o) begin
        nstb++;
        if (nstb == 2) begin at = j; chk("fs_val", int'(out_o), v); end
      end
    end
    chk("fs_lat", at, 1025);
  endtask

  // After a restart, count cycles to the first strobe (bounded).
  task automatic restart_latency(input int din, input int k, input int exp_out);
    int at;
    at = -1;
    step(din, k, 1'b1);
    for (int j = 1; j <= 40 && at < 0; j++) begin
      step(din, k, 1'b0);
      if (valid_o) begin at = j + 1; chk("rs_val", int'(out_o), exp_out); end
    end
    chk("rs_lat", at, BLANK + (1 << clamp_k(k)) + 1);
  endtask

  initial begin
    int guard;
    model_reset();
    do_reset();

    // k=0 pass-through ramp
    for (int i = 0; i < 20; i++) step(i, 0, 1'b0);

    // k=2 constant, then k=1 block of -3,-4 aligned by a restart
    for (int i = 0; i < 16; i++) step(100, 2, 1'b0);
    restart_latency(-3, 1, -3);
    step(-3, 1, 1'b0);
    step(-4, 1, 1'b0);
    chk("floor_-3.5", int'(out_o), -4);

    // Full-scale clamp, both polarities
    full_scale(8191);
    full_scale(-8192);

    // Restart after 5 samples of a k=3 block, input switched at the restart
    do_reset();
    step(0, 3, 1'b0);
    for (int i = 0; i < 5; i++) step(1000, 3, 1'b0);
    restart_latency(-500, 3, -500);

    // Restart on the completion cycle, then again during BLANK
    guard = 0;
    while (!model_at_done() && guard < 64) begin step(7, 1, 1'b0); guard++; end
    chk("align_guard", int'(guard < 64), 1);
    step(9, 1, 1'b1);
    step(9, 1, 1'b0);
    restart_latency(-20, 1, -20);

    // Exponent change mid-block, then an async reset mid-block
    for (int i = 0; i < 2; i++) step(40, 2, 1'b0);
    for (int i = 0; i < 40; i++) step(i * 3 - 50, 4, 1'b0);
    for (int i = 0; i < 5; i++) step(123, 4, 1'b0);
    do_reset();
    for (int i = 0; i < 20; i++) step(-77, 2, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int din, k;
      bit rs;
      din = int'($urandom_range(16383)) - 8192;
      k   = ($urandom_range(15) == 0) ? int'($urandom_range(15)) : int'($urandom_range(4));
      rs  = ($urandom_range(39) == 0);
      if ($urandom_range(499) == 0) do_reset();
      step(din, k, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
